// File: rtl/jt10_adpcmb_pkg.sv
// Shared constants and helpers for the multi-channel ADPCM-B decoder.
package jt10_adpcmb_pkg;

  localparam int STEP_MIN_DEF = 127;
  localparam int STEP_MAX_DEF = 24576;

  // Step-size multiplier, indexed by nibble magnitude; the result is scaled by 1/64.
  function automatic logic [7:0] step_mul(input logic [2:0] mag);
    case (mag)
      3'd4:    step_mul = 8'd77;
      3'd5:    step_mul = 8'd102;
      3'd6:    step_mul = 8'd128;
      3'd7:    step_mul = 8'd153;
      default: step_mul = 8'd57;
    endcase
  endfunction

  // Clamp the raw next step into [lo, hi]. hi must fit in 15 bits.
  function automatic logic [14:0] clamp_step(input logic [16:0] ns, input int lo, input int hi);
    if (int'(ns) < lo)      clamp_step = 15'(lo);
    else if (int'(ns) > hi) clamp_step = 15'(hi);
    else                    clamp_step = ns[14:0];
  endfunction

endpackage

// File: rtl/jt10_adpcmb_core.sv
// Stateless ADPCM-B arithmetic. The S2 half produces delta and raw next step
// from (step, mag); the S3 half applies the registered delta to x.
module jt10_adpcmb_core
  import jt10_adpcmb_pkg::*;
#(
  parameter int XW  = 16,
  localparam int NXW = XW + 2
) (
  input  logic [14:0]          step,
  input  logic [2:0]           mag,
  output logic [15:0]          d,
  output logic [16:0]          ns,
  input  logic signed [XW-1:0] x,
  input  logic                 sign,
  input  logic [15:0]          d_in,
  output logic [NXW-1:0]       nx
);

  logic [18:0]    dprod;
  logic [22:0]    sprod;
  logic [NXW-1:0] xe, de;

  // (2*mag+1)*step/8 and step*tab/64. The sum is two bits wider than x:
  // d can reach 46080, which would overflow an XW+1 sum when XW=16.
  always_comb begin
    dprod = 19'({mag, 1'b1}) * 19'(step);
    sprod = 23'(step) * 23'(step_mul(mag));
    d     = dprod[18:3];
    ns    = sprod[22:6];
    xe    = NXW'(x);
    de    = NXW'(d_in);
    nx    = sign ? (xe - de) : (xe + de);
  end

endmodule

// File: rtl/jt10_adpcmb_mch.sv
// Time-multiplexed ADPCM-B decoder: one 4-stage pipeline shared by CH
// channels, per-channel predictor state in register arrays.
module jt10_adpcmb_mch
  import jt10_adpcmb_pkg::*;
#(
  parameter int CH       = 2,
  parameter int XW       = 16,
  parameter int STEP_MIN = STEP_MIN_DEF,
  parameter int STEP_MAX = STEP_MAX_DEF,
  localparam int CW      = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic [3:0]    data,
  input  logic [CW-1:0] ch_in,
  input  logic          adv,
  output logic          ready,
  input  logic [CH-1:0] chon,
  input  logic [CH-1:0] clr,
  output logic [15:0]   pcm,
  output logic [CW-1:0] pcm_ch,
  output logic          pcm_valid
);

  localparam int NXW    = XW + 2;
  localparam int STAGES = 2;

  // Per-channel predictor state.
  logic [CH-1:0][XW-1:0] x_r;
  logic [CH-1:0][14:0]   step_r;

  // Stage tags: index 0 = S1, 1 = S2, 2 = S3 (result waiting for writeback).
  logic [STAGES:0]          vld_pipe;
  logic [STAGES:0][CW-1:0]  ch_pipe;

  logic [3:0]           data1;
  logic [XW-1:0]        x1, x2;
  logic [14:0]          step1;
  logic                 sign2;
  logic [15:0]          d2;
  logic [16:0]          ns2, ns3;
  logic [NXW-1:0]       nx3;

  logic [15:0]          d_c;
  logic [16:0]          ns_c;
  logic [NXW-1:0]       nx_c;

  logic                 wb_en, wb_on, xfer;
  logic [XW-1:0]        wb_x, rd_x;
  logic [14:0]          wb_step, rd_step;
  logic [STAGES:0]      hit;

  jt10_adpcmb_core #(.XW(XW)) u_core (
    .step (step1),
    .mag  (data1[2:0]),
    .d    (d_c),
    .ns   (ns_c),
    .x    (x2),
    .sign (sign2),
    .d_in (d2),
    .nx   (nx_c)
  );

  // Same-channel hazard detection over every stage that still has to write back.
  always_comb begin
    for (int i = 0; i <= STAGES; i++)
      hit[i] = vld_pipe[i] && (ch_pipe[i] == ch_in);
    ready = ~|hit;
    xfer  = cen && adv && ready && !clr[ch_in];
  end

  // Writeback values: saturate x to XW bits, clamp step; a disabled channel
  // writes its reset values instead.
  always_comb begin
    wb_en = vld_pipe[2] && !clr[ch_pipe[2]];
    wb_on = chon[ch_pipe[2]];
    if (nx3[NXW-1:XW-1] == {3{nx3[NXW-1]}}) wb_x = nx3[XW-1:0];
    else if (nx3[NXW-1])                    wb_x = {1'b1, {(XW-1){1'b0}}};
    else                                    wb_x = {1'b0, {(XW-1){1'b1}}};
    wb_step = clamp_step(ns3, STEP_MIN, STEP_MAX);
    if (!wb_on) begin
      wb_x    = '0;
      wb_step = 15'(STEP_MIN);
    end
  end

  // S1 state read, forwarding a same-edge writeback so S1 never sees stale state.
  always_comb begin
    rd_x    = x_r[ch_in];
    rd_step = step_r[ch_in];
    if (wb_en && (ch_pipe[2] == ch_in)) begin
      rd_x    = wb_x;
      rd_step = wb_step;
    end
    if (!chon[ch_in]) begin
      rd_x    = '0;
      rd_step = 15'(STEP_MIN);
    end
  end

  // Pipeline advance, writeback, clear and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe  <= '0;
      ch_pipe   <= '0;
      data1     <= '0;
      x1        <= '0;
      step1     <= 15'(STEP_MIN);
      sign2     <= 1'b0;
      x2        <= '0;
      d2        <= '0;
      ns2       <= '0;
      nx3       <= '0;
      ns3       <= '0;
      pcm       <= '0;
      pcm_ch    <= '0;
      pcm_valid <= 1'b0;
      for (int i = 0; i < CH; i++) begin
        x_r[i]    <= '0;
        step_r[i] <= 15'(STEP_MIN);
      end
    end else if (cen) begin
      // S1
      vld_pipe[0] <= xfer;
      ch_pipe[0]  <= ch_in;
      data1       <= data;
      x1          <= rd_x;
      step1       <= rd_step;
      // S2
      vld_pipe[1] <= vld_pipe[0] && !clr[ch_pipe[0]];
      ch_pipe[1]  <= ch_pipe[0];
      sign2       <= data1[3];
      x2          <= x1;
      d2          <= d_c;
      ns2         <= ns_c;
      // S3
      vld_pipe[2] <= vld_pipe[1] && !clr[ch_pipe[1]];
      ch_pipe[2]  <= ch_pipe[1];
      nx3         <= nx_c;
      ns3         <= ns2;
      // S4
      pcm_valid <= wb_en;
      if (wb_en) begin
        pcm    <= wb_x[XW-1 -: 16];
        pcm_ch <= ch_pipe[2];
      end
      // Clear and disable dominate the writeback.
      for (int i = 0; i < CH; i++) begin
        if (clr[i] || !chon[i]) begin
          x_r[i]    <= '0;
          step_r[i] <= 15'(STEP_MIN);
        end else if (wb_en && (ch_pipe[2] == CW'(i))) begin
          x_r[i]    <= wb_x;
          step_r[i] <= wb_step;
        end
      end
    end
  end

endmodule
